// File: rtl/interpo_coef_reader_pkg.sv
// ---------------------------------------------------------------------------
// interpo_coef_reader_pkg
// Shared definitions for the coefficient RAM read-side engine:
//   - default geometry of the coefficient RAM (DEPTH/ADDR_W/DATA_W)
//   - FSM state encoding
//   - count clamp and modulo-DEPTH address increment helpers
// ---------------------------------------------------------------------------
package interpo_coef_reader_pkg;

  localparam int unsigned DEF_DEPTH  = 40;
  localparam int unsigned DEF_ADDR_W = 6;
  localparam int unsigned DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Requested word count limited to the RAM depth.
  function automatic int unsigned clamp_count(input int unsigned n, input int unsigned depth);
    return (n > depth) ? depth : n;
  endfunction

  // Next address, wrapping from depth-1 back to 0.
  function automatic int unsigned wrap_inc(input int unsigned a, input int unsigned depth);
    return (a + 1 >= depth) ? 0 : a + 1;
  endfunction

endpackage

// File: rtl/interpo_coef_fifo2.sv
// ---------------------------------------------------------------------------
// interpo_coef_fifo2
// Two-entry shift FIFO; entry 0 is always the head so the head is a plain
// register output.
//   clk, rst_n    : clock, async active-low reset
//   flush_i       : drop all entries (wins over push/pop)
//   push_i/data_i : write one entry
//   pop_i         : remove the head entry (ignored when empty)
//   head_o        : head entry, held while not popped
//   count_o       : occupancy 0..2
//   empty_o       : count_o == 0
// ---------------------------------------------------------------------------
module interpo_coef_fifo2 #(
  parameter int unsigned W = 39
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   count_o,
  output logic         empty_o
);

  logic [W-1:0] e0_q, e0_d;
  logic [W-1:0] e1_q, e1_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         pop_ok;
  logic         push_ok;

  // Occupancy and entry update.
  always_comb begin
    e0_d    = e0_q;
    e1_d    = e1_q;
    cnt_d   = cnt_q;
    pop_ok  = pop_i && (cnt_q != 2'd0);
    push_ok = push_i && ((cnt_q != 2'd2) || pop_ok);
    if (flush_i) begin
      e0_d  = '0;
      e1_d  = '0;
      cnt_d = '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (cnt_q == 2'd0) e0_d = data_i;
          else               e1_d = data_i;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          e0_d  = e1_q;
          cnt_d = cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            e0_d = data_i;
          end else begin
            e0_d = e1_q;
            e1_d = data_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= '0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  assign head_o  = e0_q;
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == 2'd0);

endmodule

// File: rtl/interpo_coef_reader.sv
// ---------------------------------------------------------------------------
// interpo_coef_reader
// Fetches a contiguous, wrapping run of words from port 2 of the coefficient
// RAM (read-only Avalon-MM, read latency 1) and streams them in order.
//   clk, reset_n          : clock, async active-low reset
//   start/start_addr/num_words : run command, accepted only while idle
//   abort                 : synchronous cancel, no done pulse
//   busy, done            : run in progress / one-cycle completion pulse
//   ram_*                 : RAM port-2 master signals
//   coef_data/index/last/valid, coef_ready : output stream
// ---------------------------------------------------------------------------
module interpo_coef_reader
  import interpo_coef_reader_pkg::*;
#(
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] num_words,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [3:0]        ram_byteenable,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata,
  output logic [DATA_W-1:0] coef_data,
  output logic [ADDR_W-1:0] coef_index,
  output logic              coef_last,
  output logic              coef_valid,
  input  logic              coef_ready
);

  localparam int unsigned ENTRY_W = DATA_W + ADDR_W + 1;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;          // next read address
  logic [ADDR_W-1:0] left_q, left_d;          // reads still to issue
  logic [ADDR_W-1:0] idx_q, idx_d;            // run position of next read
  logic              pend_q, pend_d;          // read issued last cycle
  logic [ADDR_W-1:0] pend_idx_q, pend_idx_d;
  logic              pend_last_q, pend_last_d;
  logic              done_q, done_d;

  logic [ADDR_W-1:0]  start_cnt;
  logic               issue;
  logic               issue_ok;
  logic               pop;
  logic               push;
  logic [ENTRY_W-1:0] head;
  logic [1:0]         fifo_cnt;
  logic               fifo_empty;
  logic               head_last;

  assign start_cnt = ADDR_W'(clamp_count(32'(num_words), DEPTH));
  assign pop       = !fifo_empty && coef_ready;

  // Reserve a buffer slot for every read in flight so a stalled stream
  // can never overflow, while a free-running stream keeps one read/cycle.
  assign issue_ok  = (3'(fifo_cnt) + 3'(pend_q)) < (3'd2 + 3'(pop));
  assign issue     = (state_q == FETCH) && !abort && issue_ok && (left_q != '0);

  // In-flight data is dropped on abort.
  assign push      = pend_q && !abort;
  assign head_last = head[0];

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start && (start_cnt != '0)) state_d = FETCH;
        FETCH:   if (issue && (left_q == ADDR_W'(1))) state_d = DRAIN;
        DRAIN:   if (pop && head_last) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath / output next values.
  always_comb begin
    addr_d      = addr_q;
    left_d      = left_q;
    idx_d       = idx_q;
    pend_d      = issue;
    pend_idx_d  = idx_q;
    pend_last_d = (left_q == ADDR_W'(1));
    done_d      = 1'b0;
    if (!abort) begin
      if ((state_q == IDLE) && start) begin
        addr_d = start_addr;
        left_d = start_cnt;
        idx_d  = '0;
        done_d = (start_cnt == '0);
      end
      if (issue) begin
        addr_d = ADDR_W'(wrap_inc(32'(addr_q), DEPTH));
        left_d = left_q - ADDR_W'(1);
        idx_d  = idx_q + ADDR_W'(1);
      end
      if ((state_q == DRAIN) && pop && head_last) done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q      <= '0;
      left_q      <= '0;
      idx_q       <= '0;
      pend_q      <= 1'b0;
      pend_idx_q  <= '0;
      pend_last_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      left_q      <= left_d;
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      pend_idx_q  <= pend_idx_d;
      pend_last_q <= pend_last_d;
      done_q      <= done_d;
    end
  end

  interpo_coef_fifo2 #(
    .W (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .flush_i (abort),
    .push_i  (push),
    .data_i  ({ram_readdata, pend_idx_q, pend_last_q}),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (fifo_cnt),
    .empty_o (fifo_empty)
  );

  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign ram_address    = addr_q;
  assign ram_chipselect = issue;
  assign ram_write      = 1'b0;
  assign ram_byteenable = 4'hF;
  assign ram_clken      = 1'b1;
  assign coef_valid     = !fifo_empty;
  assign coef_data      = head[ENTRY_W-1 -: DATA_W];
  assign coef_index     = head[ADDR_W:1];
  assign coef_last      = head_last;

endmodule

// File: tb/tb_interpo_coef_reader.sv
// Scoreboard bench: runs are expanded into expected beats/addresses at start
// time; a negedge monitor pops and compares whenever the DUT presents them.
module tb_interpo_coef_reader;

  localparam int unsigned DEPTH = 40;
  localparam int unsigned AW    = 6;
  localparam int unsigned DW    = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW-1:0] num_words = '0;
  logic          abort = 1'b0;
  logic          coef_ready = 1'b0;
  logic          busy, done, ram_chipselect, ram_write, ram_clken;
  logic [AW-1:0] ram_address, coef_index;
  logic [3:0]    ram_byteenable;
  logic [DW-1:0] ram_readdata, coef_data;
  logic          coef_last, coef_valid;

  interpo_coef_reader dut (
    .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr),
    .num_words(num_words), .abort(abort), .busy(busy), .done(done),
    .ram_address(ram_address), .ram_chipselect(ram_chipselect),
    .ram_write(ram_write), .ram_byteenable(ram_byteenable), .ram_clken(ram_clken),
    .ram_readdata(ram_readdata), .coef_data(coef_data), .coef_index(coef_index),
    .coef_last(coef_last), .coef_valid(coef_valid), .coef_ready(coef_ready)
  );

  always #5 clk = ~clk;

  // RAM port-2 model: address registered on the edge, data valid next cycle.
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_q = '0;
  always @(posedge clk) if (ram_chipselect) rd_q <= mem[ram_address];
  assign ram_readdata = rd_q;

  typedef struct {
    logic [DW-1:0] data;
    int            idx;
    bit            last;
  } beat_t;

  beat_t exp_q[$];
  int    exp_addr_q[$];
  int    exp_done = 0;

  int checks = 0, errors = 0;
  int cyc = 0;
  int start_cyc = 0, first_cyc = 0, done_cyc = 0, cs_cnt = 0;
  bit first_seen = 0, done_seen = 0;
  int rdy_mode = 0;
  int phase = 0;
  bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: a run is a list of words mem[(sa+i) mod DEPTH].
  task automatic model_run(input int sa, input int n);
    int ne;
    beat_t b;
    ne = (n > int'(DEPTH)) ? int'(DEPTH) : n;
    for (int i = 0; i < ne; i++) begin
      b.data = mem[(sa + i) % DEPTH];
      b.idx  = i;
      b.last = (i == ne - 1);
      exp_q.push_back(b);
      exp_addr_q.push_back((sa + i) % DEPTH);
    end
    exp_done++;
  endtask

  // Ready driver.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       coef_ready = 1'b1;
      1:       coef_ready = pat[phase % 4];
      default: coef_ready = 1'($urandom_range(0, 1));
    endcase
    phase++;
  end

  // Monitor.
  beat_t         e;
  bit            stalled = 0;
  logic [DW-1:0] s_data;
  logic [AW-1:0] s_idx;
  logic          s_last;
  always @(negedge clk) begin
    if (reset_n) begin
      if (stalled && !abort) begin
        chk("stall_valid", coef_valid, 1);
        chk("stall_data", coef_data, s_data);
        chk("stall_index", coef_index, s_idx);
        chk("stall_last", coef_last, s_last);
      end
      if (coef_valid && !first_seen) begin
        first_seen = 1;
        first_cyc  = cyc;
      end
      if (coef_valid && coef_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: actual index=%0d data=%0h required none", coef_index, coef_data);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", coef_data, e.data);
          chk("beat_index", coef_index, e.idx);
          chk("beat_last", coef_last, e.last);
        end
      end
      stalled = coef_valid && !coef_ready && !abort;
      s_data  = coef_data;
      s_idx   = coef_index;
      s_last  = coef_last;
      if (ram_chipselect) begin
        cs_cnt++;
        if (exp_addr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_read: actual addr=%0d required no read", ram_address);
        end else begin
          chk("read_addr", ram_address, exp_addr_q.pop_front());
        end
      end
      if (done) begin
        chk("done_expected", (exp_done > 0), 1);
        if (exp_done > 0) exp_done--;
        done_seen = 1;
        done_cyc  = cyc;
      end
    end else begin
      stalled = 0;
    end
  end

  task automatic do_start(input int sa, input int n);
    @(posedge clk); #1;
    start      = 1'b1;
    start_addr = AW'(sa);
    num_words  = AW'(n);
    model_run(sa, n);
    first_seen = 0;
    done_seen  = 0;
    cs_cnt     = 0;
    @(negedge clk);
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string name);
    int k;
    k = 0;
    while (!done_seen && k < limit) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (!done_seen) begin
      checks++; errors++;
      $display("FAIL %s_timeout: actual no done after %0d cycles required done", name, limit);
    end
  endtask

  task automatic flush_model();
    exp_q.delete();
    exp_addr_q.delete();
    exp_done = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = DW'(i) * 32'h01010101;

    // Reset state.
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", coef_valid, 0);
    chk("rst_data", coef_data, 0);
    chk("rst_index", coef_index, 0);
    chk("rst_last", coef_last, 0);
    chk("rst_cs", ram_chipselect, 0);
    chk("rst_addr", ram_address, 0);
    chk("const_write", ram_write, 0);
    chk("const_be", ram_byteenable, 4'hF);
    chk("const_clken", ram_clken, 1);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Full-depth run, ready high.
    rdy_mode = 0;
    do_start(0, 40);
    wait_done(200, "full_run");
    chk("full_first_valid_lat", first_cyc - start_cyc, 3);
    chk("full_done_lat", done_cyc - start_cyc, 43);
    chk("full_reads", cs_cnt, 40);
    chk("full_all_beats", exp_q.size(), 0);
    chk("full_idle", busy, 0);

    // Wrapping run.
    do_start(38, 5);
    wait_done(100, "wrap_run");
    chk("wrap_done_lat", done_cyc - start_cyc, 8);
    chk("wrap_reads", cs_cnt, 5);
    chk("wrap_all_beats", exp_q.size(), 0);

    // Zero-length run.
    do_start(7, 0);
    wait_done(20, "zero_run");
    chk("zero_done_lat", done_cyc - start_cyc, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("zero_reads", cs_cnt, 0);
    chk("zero_no_valid", first_seen, 0);

    // Backpressure pattern 1,0,0,1.
    rdy_mode = 1;
    do_start(12, 8);
    wait_done(200, "bp_run");
    chk("bp_all_beats", exp_q.size(), 0);
    chk("bp_reads", cs_cnt, 8);

    // Random runs with random data and random ready.
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = $urandom;
    rdy_mode = 2;
    for (int r = 0; r < 8; r++) begin
      do_start(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 50)));
      wait_done(600, "rand_run");
      chk("rand_all_beats", exp_q.size(), 0);
      chk("rand_no_addr_left", exp_addr_q.size(), 0);
    end

    // Abort in cycle 5 of a 20-word run.
    rdy_mode = 0;
    @(posedge clk);
    do_start(10, 20);
    repeat (4) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    flush_model();
    chk("abort_valid", coef_valid, 0);
    chk("abort_busy", busy, 0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("abort_stays_empty", coef_valid, 0);
    end
    chk("abort_no_done", done_seen, 0);
    do_start(35, 6);
    wait_done(100, "post_abort_run");
    chk("post_abort_done_lat", done_cyc - start_cyc, 9);
    chk("post_abort_beats", exp_q.size(), 0);

    // Asynchronous reset mid-run.
    do_start(5, 20);
    repeat (6) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_valid", coef_valid, 0);
    chk("mid_rst_data", coef_data, 0);
    chk("mid_rst_index", coef_index, 0);
    chk("mid_rst_last", coef_last, 0);
    chk("mid_rst_cs", ram_chipselect, 0);
    chk("mid_rst_addr", ram_address, 0);
    flush_model();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    do_start(0, 50);
    wait_done(200, "clamp_run");
    chk("clamp_reads", cs_cnt, 40);
    chk("clamp_done_lat", done_cyc - start_cyc, 43);
    chk("clamp_beats", exp_q.size(), 0);

    repeat (3) @(posedge clk);
    #1;
    chk("final_no_done_owed", exp_done, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
